// File: rtl/bin2dec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bin2dec_pkg
// Purpose : Shared types, ASCII constants and the digit-count helper for the
//           bin2dec_stream binary-to-decimal ASCII streamer.
// Contents: state_t  - converter state encoding
//           ndig()   - decimal digits needed to print 2^data_w-1
//           ASCII_*  - character constants
// Revision: 1.0 - initial release
// ============================================================================
package bin2dec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2,
        EOL     = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Digits of the largest unsigned value representable in data_w bits.
    function automatic int ndig(input int data_w);
        logic [63:0] v;
        int          n;
        v = (data_w >= 64) ? {64{1'b1}} : ((64'd1 << data_w) - 64'd1);
        n = 0;
        while (v != 64'd0) begin
            v = v / 64'd10;
            n++;
        end
        return (n < 1) ? 1 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2dec_dabble_step.sv
`default_nettype none
// ============================================================================
// Module  : bin2dec_dabble_step
// Purpose : One combinational double-dabble iteration: every BCD nibble >= 5
//           gets +3, then the vector shifts left by one taking bit_i as LSB.
// Ports   : bcd_i [4*NDIG] - current packed BCD digits (digit 0 in LSBs)
//           bit_i          - next binary bit, MSB first
//           bcd_o [4*NDIG] - BCD after adjust and shift
// Revision: 1.0 - initial release
// ============================================================================
module bin2dec_dabble_step #(
    parameter int NDIG = 5
) (
    input  logic [4*NDIG-1:0] bcd_i,
    input  logic              bit_i,
    output logic [4*NDIG-1:0] bcd_o
);

    logic [4*NDIG-1:0] w_adj;
    // NDIG is sized for the full input range, so the bit shifted out of the
    // top digit is always zero and is intentionally discarded.
    logic              w_unused_msb;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        assign w_adj[4*g +: 4] = (bcd_i[4*g +: 4] >= 4'd5) ? (bcd_i[4*g +: 4] + 4'd3)
                                                           : bcd_i[4*g +: 4];
    end

    assign w_unused_msb = w_adj[4*NDIG-1];
    assign bcd_o        = {w_adj[4*NDIG-2:0], bit_i};

endmodule
`default_nettype wire

// File: rtl/bin2dec_stream.sv
`default_nettype none
// ============================================================================
// Module  : bin2dec_stream
// Purpose : Captures a DATA_W-bit word on start/ready, converts it to BCD one
//           bit per cycle, then streams ASCII decimal digits MSB first over a
//           valid/ready interface with a last flag.
// Ports   : clk, rst (sync, active-high)
//           start, hex_data[DATA_W], ready         - request side
//           ascii_data[8], valid, ascii_ready, last - character stream side
// Params  : DATA_W (4..64), SIGNED (leading '-'), LEAD_ZERO (zero padding)
// Options : define BIN2DEC_STREAM_EOL_EN to append CR LF after each number;
//           last then marks the LF instead of digit 0.
// Revision: 1.0 - initial release
// ============================================================================
module bin2dec_stream
    import bin2dec_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int SIGNED    = 0,
    parameter int LEAD_ZERO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] hex_data,
    output logic              ready,
    output logic [7:0]        ascii_data,
    output logic              valid,
    input  logic              ascii_ready,
    output logic              last
);

    localparam int NDIG  = ndig(DATA_W);
    localparam int PTR_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mag_q, mag_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                sign_q, sign_d;   // '-' still owed to the sink
`ifdef BIN2DEC_STREAM_EOL_EN
    logic                lf_q, lf_d;       // 0: CR pending, 1: LF pending
`endif

    logic [4*NDIG-1:0]   w_bcd_step;
    logic [DATA_W-1:0]   w_mag_in;
    logic                w_neg_in;
    logic [PTR_W-1:0]    w_lz_ptr;
    logic [3:0]          w_nib;
    logic                w_xfer;

    bin2dec_dabble_step #(.NDIG(NDIG)) u_step (
        .bcd_i (bcd_q),
        .bit_i (mag_q[DATA_W-1]),
        .bcd_o (w_bcd_step)
    );

    // Negation in DATA_W bits maps the most negative value onto itself,
    // which read as unsigned is exactly its magnitude.
    assign w_neg_in = (SIGNED != 0) && hex_data[DATA_W-1];
    assign w_mag_in = w_neg_in ? -hex_data : hex_data;

    // Highest non-zero digit; stays at 0 for an all-zero value so a lone '0'
    // is still printed.
    always_comb begin
        w_lz_ptr = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                w_lz_ptr = PTR_W'(i);
            end
        end
    end

    assign w_nib  = bcd_q[{ptr_q, 2'b00} +: 4];
    assign w_xfer = valid && ascii_ready;

    // Outputs decode registered state only, so they hold steady under
    // backpressure without extra holding registers.
    always_comb begin
        ready      = (state_q == IDLE);
        valid      = (state_q == EMIT) || (state_q == EOL);
        ascii_data = 8'h00;
        last       = 1'b0;
        case (state_q)
            EMIT: begin
                if (sign_q) begin
                    ascii_data = ASCII_MINUS;
                end else begin
                    ascii_data = ASCII_ZERO + {4'h0, w_nib};
`ifndef BIN2DEC_STREAM_EOL_EN
                    last       = (ptr_q == '0);
`endif
                end
            end
`ifdef BIN2DEC_STREAM_EOL_EN
            EOL: begin
                ascii_data = lf_q ? ASCII_LF : ASCII_CR;
                last       = lf_q;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sign_d  = sign_q;
`ifdef BIN2DEC_STREAM_EOL_EN
        lf_d    = lf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_d   = w_mag_in;
                    sign_d  = w_neg_in;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(DATA_W);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt_q != '0) begin
                    mag_d = {mag_q[DATA_W-2:0], 1'b0};
                    bcd_d = w_bcd_step;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Extra cycle: the digit pointer is set from the final
                    // BCD value before the first character is presented.
                    ptr_d   = (LEAD_ZERO != 0) ? PTR_W'(NDIG - 1) : w_lz_ptr;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (w_xfer) begin
                    if (sign_q) begin
                        sign_d = 1'b0;
                    end else if (ptr_q == '0) begin
`ifdef BIN2DEC_STREAM_EOL_EN
                        lf_d    = 1'b0;
                        state_d = EOL;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        ptr_d = ptr_q - PTR_W'(1);
                    end
                end
            end
`ifdef BIN2DEC_STREAM_EOL_EN
            EOL: begin
                if (w_xfer) begin
                    if (lf_q) begin
                        state_d = IDLE;
                    end else begin
                        lf_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sign_q  <= 1'b0;
`ifdef BIN2DEC_STREAM_EOL_EN
            lf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sign_q  <= sign_d;
`ifdef BIN2DEC_STREAM_EOL_EN
            lf_q    <= lf_d;
`endif
        end
    end

endmodule
`default_nettype wire
